// File: rtl/bsg_comm_link_traffic_pkg.sv
// Shared types and constants for the comm-link traffic generator/checker.
package bsg_comm_link_traffic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bits [15:0] carry the sequence number; filler bytes start here.
    localparam int seq_width_lp          = 16;
    localparam int pattern_first_byte_lp = 2;

endpackage

// File: rtl/bsg_comm_link_traffic_pattern.sv
// Combinational packet pattern: sequence number in the low 16 bits, every
// higher byte b holds (k[7:0] + b) mod 256.
module bsg_comm_link_traffic_pattern
    import bsg_comm_link_traffic_pkg::*;
#(
    parameter int width_p = 80
) (
    input  logic [seq_width_lp-1:0] k,
    output logic [width_p-1:0]      pattern
);

    // Build the pattern byte by byte from the sequence number.
    always_comb begin
        pattern = '0;
        pattern[seq_width_lp-1:0] = k;
        for (int b = pattern_first_byte_lp; b < width_p / 8; b++) begin
            pattern[b*8 +: 8] = k[7:0] + 8'(b);
        end
    end

endmodule

// File: rtl/bsg_comm_link_traffic_node.sv
// Core-side traffic generator and checker for one comm-link node.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for en_i
//   RUN   | sending packets and checking looped-back packets together
//   DRAIN | all packets sent, still collecting; idle counter armed
//   DONE  | finished (all received or timed out); left only by reset_i
module bsg_comm_link_traffic_node
    import bsg_comm_link_traffic_pkg::*;
#(
    parameter int width_p      = 80,
    parameter int iterations_p = 16,
    parameter int timeout_p    = 1024,
    parameter int ctr_width_p  = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   ready_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   yumi_o,
    output logic [ctr_width_p-1:0] sent_o,
    output logic [ctr_width_p-1:0] recv_o,
    output logic [ctr_width_p-1:0] err_o,
    output logic                   timeout_o,
    output logic                   done_o
);

    localparam logic [ctr_width_p-1:0] iter_lp = ctr_width_p'(iterations_p);
    localparam logic [ctr_width_p-1:0] one_lp  = ctr_width_p'(1);
    localparam int idle_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam logic [idle_width_lp-1:0] idle_last_lp = idle_width_lp'(timeout_p - 1);

    state_e                   state_r;
    logic [ctr_width_p-1:0]   sent_r, recv_r, err_r;
    logic [idle_width_lp-1:0] idle_r;
    logic                     timeout_r, done_r;

    logic [seq_width_lp-1:0]  send_k, recv_k;
    logic [width_p-1:0]       exp_data;
    logic                     xfer, mismatch;
    logic [ctr_width_p-1:0]   sent_nxt, recv_nxt;

    assign send_k = seq_width_lp'(sent_r);
    assign recv_k = seq_width_lp'(recv_r);

    bsg_comm_link_traffic_pattern #(.width_p(width_p)) send_pattern (
        .k       (send_k),
        .pattern (data_o)
    );

    bsg_comm_link_traffic_pattern #(.width_p(width_p)) expect_pattern (
        .k       (recv_k),
        .pattern (exp_data)
    );

    // Outputs depend only on registered state, except yumi_o which follows v_i.
    assign v_o    = (state_r == RUN) && (sent_r < iter_lp);
    assign yumi_o = v_i && ((state_r == RUN) || (state_r == DRAIN)) && (recv_r < iter_lp);

    assign xfer     = v_o && ready_i;
    assign mismatch = (data_i != exp_data);
    assign sent_nxt = sent_r + ctr_width_p'(xfer);
    assign recv_nxt = recv_r + ctr_width_p'(yumi_o);

    assign sent_o    = sent_r;
    assign recv_o    = recv_r;
    assign err_o     = err_r;
    assign timeout_o = timeout_r;
    assign done_o    = done_r;

    // Sequencer, counters and status; transitions look at the post-event
    // counts so done_o rises the cycle right after the final receive.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            sent_r    <= '0;
            recv_r    <= '0;
            err_r     <= '0;
            idle_r    <= '0;
            timeout_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            sent_r <= sent_nxt;
            recv_r <= recv_nxt;
            if (yumi_o && mismatch && (err_r != '1)) begin
                err_r <= err_r + one_lp;
            end

            case (state_r)
                IDLE: begin
                    if (en_i) state_r <= RUN;
                end
                RUN: begin
                    if (sent_nxt == iter_lp) begin
                        if (recv_nxt == iter_lp) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= DRAIN;
                            idle_r  <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (yumi_o) begin
                        idle_r <= '0;
                        if (recv_nxt == iter_lp) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else if (idle_r == idle_last_lp) begin
                        state_r   <= DONE;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                    end else begin
                        idle_r <= idle_r + 1'b1;
                    end
                end
                DONE: begin
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_comm_link_traffic_node.sv
// Bench for bsg_comm_link_traffic_node: loopback environment through a
// 2-deep FIFO with loss/corruption/backpressure knobs, plus a
// transaction-level model compared every cycle.
module tb_bsg_comm_link_traffic_node;

    localparam int W  = 80;
    localparam int N  = 16;
    localparam int TO = 1024;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          en_i = 1'b0;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          ready_i = 1'b0;
    logic          v_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          yumi_o;
    logic [CW-1:0] sent_o, recv_o, err_o;
    logic          timeout_o, done_o;

    always #5 clk = ~clk;

    bsg_comm_link_traffic_node #(
        .width_p(W), .iterations_p(N), .timeout_p(TO), .ctr_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
        .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
        .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
        .sent_o(sent_o), .recv_o(recv_o), .err_o(err_o),
        .timeout_o(timeout_o), .done_o(done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pattern built most-significant byte first with plain arithmetic.
    function automatic logic [W-1:0] pat(input int k);
        logic [W-1:0] p;
        p = '0;
        for (int b = W / 8 - 1; b >= 2; b--) p = (p << 8) | W'((k + b) % 256);
        p = (p << 16) | W'(k % 65536);
        return p;
    endfunction

    // Environment knobs
    bit bp_on = 1'b0;
    int corrupt_idx = -1;
    int drop_idx = -1;
    bit hold_extra = 1'b0;
    bit cmp_en = 1'b0;

    logic [W-1:0] fifo[$];
    logic [W-1:0] sent_log[$];
    int           push_cnt = 0;
    logic [W-1:0] pkt;

    // Model: phase 0=idle 1=run 2=drain 3=done
    int m_ph = 0, m_sent = 0, m_recv = 0, m_err = 0, m_idle = 0;
    bit m_to = 1'b0, m_done = 1'b0;
    bit tx, rx;

    function automatic bit m_vo();
        return (m_ph == 1) && (m_sent < N);
    endfunction

    function automatic bit m_yumi();
        return ((m_ph == 1) || (m_ph == 2)) && v_i && (m_recv < N);
    endfunction

    // Clock-edge process: advance model, run the loopback FIFO, drive inputs.
    initial forever begin
        @(posedge clk);
        if (reset_i) begin
            m_ph = 0; m_sent = 0; m_recv = 0; m_err = 0; m_idle = 0;
            m_to = 1'b0; m_done = 1'b0;
            fifo.delete();
            sent_log.delete();
            push_cnt = 0;
        end else begin
            tx = m_vo() && ready_i;
            rx = m_yumi();
            if (tx) m_sent++;
            if (rx) begin
                if (data_i != pat(m_recv)) m_err++;
                m_recv++;
            end
            case (m_ph)
                0: if (en_i) m_ph = 1;
                1: if (m_sent == N) begin
                       if (m_recv == N) begin m_ph = 3; m_done = 1'b1; end
                       else begin m_ph = 2; m_idle = 0; end
                   end
                2: if (rx) begin
                       m_idle = 0;
                       if (m_recv == N) begin m_ph = 3; m_done = 1'b1; end
                   end else if (m_idle == TO - 1) begin
                       m_ph = 3; m_done = 1'b1; m_to = 1'b1;
                   end else m_idle++;
                default: ;
            endcase
            if (yumi_o && fifo.size() > 0) fifo.delete(0);
            if (v_o && ready_i) begin
                pkt = data_o;
                sent_log.push_back(pkt);
                if (push_cnt != drop_idx) begin
                    if (push_cnt == corrupt_idx) pkt[20] = ~pkt[20];
                    fifo.push_back(pkt);
                end
                push_cnt++;
            end
        end
        #1;
        ready_i = (fifo.size() < 2) && (bp_on ? ($urandom_range(0, 99) < 30) : 1'b1);
        v_i     = hold_extra || (fifo.size() > 0);
        data_i  = (fifo.size() > 0) ? fifo[0] : pat(0);
    end

    logic         prev_v = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b1;
    logic [W-1:0] prev_d = '0;

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("v_o", v_o, m_vo());
            check("data_o", data_o, pat(m_sent));
            check("yumi_o", yumi_o, m_yumi());
            check("sent_o", sent_o, m_sent);
            check("recv_o", recv_o, m_recv);
            check("err_o", err_o, m_err);
            check("timeout_o", timeout_o, m_to);
            check("done_o", done_o, m_done);
            if (prev_v && !prev_rdy && !prev_rst && !reset_i && v_o)
                check("data_o_stall", data_o, prev_d);
        end
        prev_v   = v_o;
        prev_rdy = ready_i;
        prev_rst = reset_i;
        prev_d   = data_o;
    end

    task automatic start_run();
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        check("rst_v_o", v_o, 1'b0);
        check("rst_data_o", data_o, 80'h09080706050403020000);
        check("rst_sent", sent_o, 16'd0);
        check("rst_done", done_o, 1'b0);
        reset_i = 1'b0;
        en_i = 1'b1;
        @(negedge clk);
        en_i = 1'b0;
        check("en_to_v_o", v_o, 1'b1);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000 && !done_o; i++) @(negedge clk);
        check({name, "_done_reached"}, done_o, 1'b1);
    endtask

    initial begin
        check("pat0_literal", pat(0), 80'h09080706050403020000);
        check("pat5_literal", pat(5), 80'h0E0D0C0B0A0908070005);
        check("pat255_literal", pat(255), 80'h080706050403020100FF);
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;

        // Plain loopback, then extra inbound traffic after DONE
        start_run();
        wait_done("loop");
        check("loop_sent", sent_o, 16'd16);
        check("loop_recv", recv_o, 16'd16);
        check("loop_err", err_o, 16'd0);
        check("loop_timeout", timeout_o, 1'b0);
        hold_extra = 1'b1;
        repeat (5) @(negedge clk);
        check("extra_v_i", v_i, 1'b1);
        check("extra_yumi", yumi_o, 1'b0);
        check("extra_recv", recv_o, 16'd16);
        check("extra_sent", sent_o, 16'd16);
        hold_extra = 1'b0;

        // Backpressure
        bp_on = 1'b1;
        start_run();
        wait_done("bp");
        check("bp_err", err_o, 16'd0);
        check("bp_log_size", sent_log.size(), 16);
        for (int i = 0; i < sent_log.size() && i < N; i++)
            check($sformatf("bp_pkt%0d", i), sent_log[i], pat(i));
        if (sent_log.size() > 5) begin
            check("bp_pkt0_literal", sent_log[0], 80'h09080706050403020000);
            check("bp_pkt5_literal", sent_log[5], 80'h0E0D0C0B0A0908070005);
        end
        bp_on = 1'b0;

        // Corrupt the 5th looped packet
        corrupt_idx = 4;
        start_run();
        wait_done("corrupt");
        check("corrupt_err", err_o, 16'd1);
        check("corrupt_recv", recv_o, 16'd16);
        check("corrupt_timeout", timeout_o, 1'b0);
        corrupt_idx = -1;

        // Lose packet 9: drains, then times out
        drop_idx = 9;
        start_run();
        for (int i = 0; i < 200 && !(sent_o == 16 && recv_o == 15); i++) @(negedge clk);
        check("loss_drain_done_low", done_o, 1'b0);
        check("loss_drain_recv", recv_o, 16'd15);
        wait_done("loss");
        check("loss_recv", recv_o, 16'd15);
        check("loss_timeout", timeout_o, 1'b1);
        check("loss_err", err_o, 16'd6);
        drop_idx = -1;

        // Reset mid-run after 7 sends, then a clean full run
        start_run();
        for (int i = 0; i < 200 && sent_o != 7; i++) @(negedge clk);
        check("mid_sent7", sent_o, 16'd7);
        reset_i = 1'b1;
        @(negedge clk);
        check("mid_v_o", v_o, 1'b0);
        check("mid_sent", sent_o, 16'd0);
        check("mid_recv", recv_o, 16'd0);
        reset_i = 1'b0;
        en_i = 1'b1;
        @(negedge clk);
        en_i = 1'b0;
        wait_done("rerun");
        check("rerun_sent", sent_o, 16'd16);
        check("rerun_recv", recv_o, 16'd16);
        check("rerun_err", err_o, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_comm_link_traffic_node.md
# bsg_comm_link_traffic_node

Synthesizable core-side traffic generator and checker for one comm-link node. It plugs directly into a `bsg_guts` core node port:

- It produces fixed-pattern packets on the node's outbound valid/ready channel.
- It consumes looped-back packets on the node's inbound valid/yumi channel.
- It checks every received packet against the expected sequence and reports counts, errors, timeout and done.

It replaces the nonsynthesizable simulation checker, so link bring-up can run on silicon.

## Interface
Parameters:
- `width_p`, 80: packet width in bits. Must be a multiple of 8 and at least 16.
- `iterations_p`, 16: number of packets to send and expect. Range 1..65535.
- `timeout_p`, 1024: idle cycles allowed in DRAIN before the node gives up.
- `ctr_width_p`, 16: width of the count outputs.

Ports:
- `clk_i`, in, 1: core clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `en_i`, in, 1: start request, sampled only in IDLE.
- `v_o`, out, 1: outbound packet valid.
- `data_o`, out, `width_p`: outbound packet.
- `ready_i`, in, 1: the link accepts the outbound packet.
- `v_i`, in, 1: inbound packet valid.
- `data_i`, in, `width_p`: inbound packet.
- `yumi_o`, out, 1: inbound packet consumed.
- `sent_o`, out, `ctr_width_p`: packets sent.
- `recv_o`, out, `ctr_width_p`: packets received.
- `err_o`, out, `ctr_width_p`: mismatching packets. Saturates at all-ones.
- `timeout_o`, out, 1: DONE was reached by timeout.
- `done_o`, out, 1: test finished.

## Operation
- Pattern P(k) for 16-bit sequence number k:
  - bits [15:0] = k.
  - Byte b, for b ≥ 2, = (k[7:0] + b) mod 256.
- States:
  - IDLE. Go to RUN when `en_i`=1.
  - RUN. Send and receive concurrently. Go to DRAIN when `sent_o` == `iterations_p` and `recv_o` < `iterations_p`. Go directly to DONE if both counts equal `iterations_p` in the same cycle.
  - DRAIN. Receive only. Go to DONE when `recv_o` == `iterations_p`, or when the idle counter reaches `timeout_p`-1 with no receive.
  - DONE. Terminal; leave only through `reset_i`.
- Send side:
  - `v_o` = 1 in RUN while `sent_o` < `iterations_p`.
  - `data_o` = P(`sent_o`[15:0]).
  - Transfer occurs when `v_o & ready_i`. `sent_o` increments on each transfer.
  - `data_o` is held stable while `v_o` = 1 and `ready_i` = 0.
- Receive side:
  - `yumi_o` = `v_i` in RUN and DRAIN; 0 in IDLE and DONE.
  - On `yumi_o`: compare `data_i` against P(`recv_o`[15:0]). On mismatch, increment `err_o`. In either case increment `recv_o`.
  - `recv_o` stops at `iterations_p`. Once reached, no more `yumi_o` is asserted.
- Idle counter:
  - Clears on every receive and on entry to DRAIN.
  - Increments each DRAIN cycle without a receive.
  - `timeout_o` is set on the timeout transition.
- Simultaneous send and receive in one cycle: both counters update.
- Extra inbound packets in DONE are not consumed: `yumi_o` stays 0.

## Timing
- Reset values: state IDLE, `v_o`=0, `yumi_o`=0, all counters 0, `timeout_o`=0, `done_o`=0. `data_o` = P(0).
- `en_i` high on cycle n: `v_o` = 1 on cycle n+1.
- `yumi_o` is combinational from `v_i` and state. No other input-to-output combinational path exists.
- All counters, `timeout_o` and `done_o` are registered. Each updates the cycle after the qualifying event.
- `done_o` rises one cycle after the final receive, or one cycle after the timeout condition.
- Reset mid-test: all state clears in the next cycle, and any in-flight packet is abandoned. `v_o` must drop in that cycle regardless of `ready_i`.

## Structure
- Package `bsg_comm_link_traffic_pkg`:
  - State enum: IDLE, RUN, DRAIN, DONE.
  - Pattern byte offset constant.
- Sub-module `bsg_comm_link_traffic_pattern` (combinational, parameter `width_p`, input k, output P(k)).
  - Instanced twice: once for send, once for the expected value.
- Error counter uses saturating increment. The other counters cannot overflow given the `iterations_p` range.

## Test plan
- Loopback: `data_o` wired to `data_i` through a 2-deep FIFO, `ready_i`=1, `iterations_p`=16 → `sent_o`=16, `recv_o`=16, `err_o`=0, `done_o`=1, `timeout_o`=0.
- Backpressure: `ready_i` random at 30% → `data_o` stable while stalled, exactly 16 distinct packets P(0)..P(15) sent in order, `err_o`=0.
- Corruption: flip bit 20 of the 5th looped packet → `err_o`=1, `recv_o`=16, `done_o`=1.
- Loss: drop packet 9 in the loopback → DRAIN entered, `recv_o`=15 → after 1024 idle cycles, `done_o`=1, `timeout_o`=1, `err_o`=6 (packets 10–15 mismatch).
- Reset mid-run after 7 sends → next cycle `v_o`=0 and counters 0. After re-enable, a full 16-packet run passes with `err_o`=0.
- Extra inbound after DONE: hold `v_i`=1 → `yumi_o`=0 and counters unchanged.
